// File: rtl/datapath_gen.sv
// Register-file datapath: A/B operand registers, shifter, ALU, C/status registers,
// and a sequential shift-add multiplier that runs alongside the rest of the datapath.
module datapath_gen #(
  parameter int unsigned W    = 16,
  parameter int unsigned NREG = 8,
  parameter int unsigned RW   = $clog2(NREG),
  parameter int unsigned PCW  = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [RW-1:0] readnum,
  input  logic [RW-1:0] writenum,
  input  logic          write,
  input  logic          loada,
  input  logic          loadb,
  input  logic          loadc,
  input  logic          loads,
  input  logic          asel,
  input  logic          bsel,
  input  logic [3:0]    vsel,
  input  logic [2:0]    ALUop,
  input  logic [1:0]    shift,
  input  logic [W-1:0]  sximm5,
  input  logic [W-1:0]  sximm8,
  input  logic [W-1:0]  mdata,
  input  logic [PCW-1:0] PC,
  output logic [W-1:0]  datapath_out,
  output logic [2:0]    Z_out,
  output logic          busy,
  output logic          done
);

  localparam int unsigned W2 = 2 * W;
  localparam int unsigned CW = $clog2(W);

  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_next;

  logic [W-1:0]  regs [NREG];
  logic [W-1:0]  rd_data, wb_data;
  logic          wb_legal;
  logic [W-1:0]  a_reg, b_reg, c_reg;
  logic [2:0]    status;
  logic [W-1:0]  ain, bin, b_shifted;
  logic [W-1:0]  sum, diff, alu_res;
  logic          alu_v;
  logic [2:0]    alu_flags;
  logic [W2-1:0] mcand, prod, prod_next;
  logic [W-1:0]  mplier;
  logic [CW-1:0] cnt;
  logic          mul_loads, mul_start, mul_last;

  assign rd_data = regs[readnum];

  always_comb begin
    wb_data  = '0;
    wb_legal = 1'b1;
    case (vsel)
      4'b0001: wb_data = mdata;
      4'b0010: wb_data = sximm8;
      4'b0100: wb_data = W'(PC);
      4'b1000: wb_data = c_reg;
      default: wb_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (write && wb_legal) begin
      regs[writenum] <= wb_data;
    end
  end

  always_comb begin
    b_shifted = b_reg;
    case (shift)
      2'b01:   b_shifted = {b_reg[W-2:0], 1'b0};
      2'b10:   b_shifted = {1'b0, b_reg[W-1:1]};
      2'b11:   b_shifted = {b_reg[W-1], b_reg[W-1:1]};
      default: b_shifted = b_reg;
    endcase
  end

  assign ain  = asel ? '0 : a_reg;
  assign bin  = bsel ? sximm5 : b_shifted;
  assign sum  = ain + bin;
  assign diff = ain - bin;

  // MUL (110) falls through to the adder so loads without loadc captures ADD flags
  always_comb begin
    alu_res = sum;
    alu_v   = (ain[W-1] == bin[W-1]) && (sum[W-1] != ain[W-1]);
    case (ALUop)
      3'b001: begin
        alu_res = diff;
        alu_v   = (ain[W-1] != bin[W-1]) && (diff[W-1] != ain[W-1]);
      end
      3'b010: begin alu_res = ain & bin; alu_v = 1'b0; end
      3'b011: begin alu_res = ~bin;      alu_v = 1'b0; end
      3'b100: begin alu_res = ain | bin; alu_v = 1'b0; end
      3'b101: begin alu_res = ain ^ bin; alu_v = 1'b0; end
      default: ;
    endcase
  end

  assign alu_flags = {alu_v, alu_res[W-1], alu_res == '0};

  assign mul_start = (state == IDLE) && (ALUop == 3'b110) && loadc;
  assign mul_last  = (state == RUN) && (cnt == CW'(W - 1));
  assign prod_next = prod + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mul_start) state_next = RUN;
      RUN:     if (mul_last)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg     <= '0;
      b_reg     <= '0;
      c_reg     <= '0;
      status    <= '0;
      done      <= 1'b0;
      mcand     <= '0;
      mplier    <= '0;
      prod      <= '0;
      cnt       <= '0;
      mul_loads <= 1'b0;
    end else begin
      done <= mul_last;
      if (loada) a_reg <= rd_data;
      if (loadb) b_reg <= rd_data;
      if (state == IDLE) begin
        if (mul_start) begin
          mcand     <= W2'(ain);
          mplier    <= bin;
          prod      <= '0;
          cnt       <= '0;
          mul_loads <= loads;
        end else begin
          if (loadc) c_reg  <= alu_res;
          if (loads) status <= alu_flags;
        end
      end else begin
        prod   <= prod_next;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + CW'(1);
        if (mul_last) begin
          c_reg <= prod_next[W-1:0];
          if (mul_loads)
            status <= {|prod_next[W2-1:W], prod_next[W-1], prod_next[W-1:0] == '0};
        end
      end
    end
  end

  assign busy         = (state == RUN);
  assign datapath_out = c_reg;
  assign Z_out        = status;

endmodule

// File: tb/tb_datapath_gen.sv
// Directed bench for datapath_gen: a 16-bit/8-register instance and a
// 32-bit/16-register instance, with hand-computed expected values.
module tb_datapath_gen;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, bsel;
  logic [3:0]  vsel;
  logic [2:0]  ALUop;
  logic [1:0]  shift;
  logic [15:0] sximm5, sximm8, mdata;
  logic [7:0]  PC;
  logic [15:0] datapath_out;
  logic [2:0]  Z_out;
  logic        busy, done;

  logic        w_reset;
  logic [3:0]  w_readnum, w_writenum;
  logic        w_write, w_loada, w_loadb, w_loadc, w_loads, w_asel, w_bsel;
  logic [3:0]  w_vsel;
  logic [2:0]  w_ALUop;
  logic [1:0]  w_shift;
  logic [31:0] w_sximm5, w_sximm8, w_mdata;
  logic [7:0]  w_PC;
  logic [31:0] w_datapath_out;
  logic [2:0]  w_Z_out;
  logic        w_busy, w_done;

  int checks = 0;
  int errors = 0;

  datapath_gen #(.W(16), .NREG(8), .PCW(8)) dut (
    .clk(clk), .reset(reset), .readnum(readnum), .writenum(writenum), .write(write),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel),
    .vsel(vsel), .ALUop(ALUop), .shift(shift), .sximm5(sximm5), .sximm8(sximm8),
    .mdata(mdata), .PC(PC), .datapath_out(datapath_out), .Z_out(Z_out),
    .busy(busy), .done(done)
  );

  datapath_gen #(.W(32), .NREG(16), .PCW(8)) dut_w (
    .clk(clk), .reset(w_reset), .readnum(w_readnum), .writenum(w_writenum), .write(w_write),
    .loada(w_loada), .loadb(w_loadb), .loadc(w_loadc), .loads(w_loads), .asel(w_asel),
    .bsel(w_bsel), .vsel(w_vsel), .ALUop(w_ALUop), .shift(w_shift), .sximm5(w_sximm5),
    .sximm8(w_sximm8), .mdata(w_mdata), .PC(w_PC), .datapath_out(w_datapath_out),
    .Z_out(w_Z_out), .busy(w_busy), .done(w_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    write = 0; loada = 0; loadb = 0; loadc = 0; loads = 0; asel = 0; bsel = 0;
    vsel = 4'b0000; ALUop = 3'b000; shift = 2'b00;
  endtask

  task automatic wr_imm(input logic [2:0] r, input logic [15:0] v);
    writenum = r; vsel = 4'b0010; sximm8 = v; write = 1;
    tick();
    clr();
  endtask

  task automatic load_ab(input logic [2:0] ra, input logic [2:0] rb);
    readnum = ra; loada = 1;
    tick();
    loada = 0; readnum = rb; loadb = 1;
    tick();
    clr();
  endtask

  task automatic alu_op(input logic [2:0] op, input logic [1:0] sh, input logic as);
    ALUop = op; shift = sh; asel = as; loadc = 1; loads = 1;
    tick();
    clr();
  endtask

  // Reads a register through A, leaving status untouched.
  task automatic read_reg(input logic [2:0] r, output logic [15:0] val);
    readnum = r; loada = 1;
    tick();
    loada = 0; bsel = 1; sximm5 = '0; ALUop = 3'b000; loadc = 1;
    tick();
    clr();
    val = datapath_out;
  endtask

  task automatic mul_wait(input int mode, output int cyc, output int dn);
    cyc = 0; dn = 0;
    while (busy && cyc < 200) begin
      cyc++;
      if (done) dn++;
      clr();
      if (mode == 1) begin
        case (cyc)
          2: begin readnum = 3'd2; loada = 1; end
          3: begin readnum = 3'd3; loadb = 1; end
          4: begin
            ALUop = 3'b000; loadc = 1; loads = 1;
            vsel = 4'b0010; sximm8 = 16'h0042; writenum = 3'd0; write = 1;
          end
          default: ;
        endcase
      end
      if (mode == 2 && cyc == 5) begin readnum = 3'd0; loada = 1; end
      tick();
    end
    if (done) dn++;
    clr();
  endtask

  task automatic w_clr();
    w_write = 0; w_loada = 0; w_loadb = 0; w_loadc = 0; w_loads = 0; w_asel = 0;
    w_bsel = 0; w_vsel = 4'b0000; w_ALUop = 3'b000; w_shift = 2'b00;
  endtask

  task automatic w_wr(input logic [3:0] r, input logic [31:0] v);
    w_writenum = r; w_vsel = 4'b0010; w_sximm8 = v; w_write = 1;
    tick();
    w_clr();
  endtask

  task automatic w_load(input logic [3:0] ra, input logic [3:0] rb);
    w_readnum = ra; w_loada = 1;
    tick();
    w_loada = 0; w_readnum = rb; w_loadb = 1;
    tick();
    w_clr();
  endtask

  logic [2:0]  op_tab [6] = '{3'b010, 3'b011, 3'b100, 3'b101, 3'b111, 3'b001};
  logic [15:0] c_tab  [6] = '{16'h0001, 16'h7FFE, 16'hFFFF, 16'hFFFE, 16'h0000, 16'hFFFE};
  logic [2:0]  z_tab  [6] = '{3'b000, 3'b000, 3'b010, 3'b010, 3'b001, 3'b110};

  initial begin
    logic [15:0] rv;
    int cyc, dn;

    clr();
    reset = 1; readnum = 0; writenum = 0; sximm5 = 0; sximm8 = 0; mdata = 0; PC = 0;
    w_clr();
    w_reset = 1; w_readnum = 0; w_writenum = 0; w_sximm5 = 0; w_sximm8 = 0; w_mdata = 0;
    w_PC = 0;
    tick(); tick();
    reset = 0;
    check("rst_c", datapath_out, 16'h0);
    check("rst_z", Z_out, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);

    // Basic add
    wr_imm(3'd0, 16'd7);
    wr_imm(3'd1, 16'd2);
    load_ab(3'd0, 3'd1);
    alu_op(3'b000, 2'b00, 1'b0);
    check("add_c", datapath_out, 16'd9);
    check("add_z", Z_out, 3'b000);

    // Read-during-write: A captures the old R0
    readnum = 3'd0; loada = 1;
    wr_imm(3'd0, 16'h0055);
    bsel = 1; sximm5 = 16'h0; ALUop = 3'b000; loadc = 1;
    tick();
    clr();
    check("rdw_old", datapath_out, 16'd7);
    read_reg(3'd0, rv);
    check("rdw_new", rv, 16'h0055);

    // Overflow boundaries
    wr_imm(3'd2, 16'h7FFF);
    wr_imm(3'd3, 16'h0001);
    load_ab(3'd2, 3'd3);
    alu_op(3'b001, 2'b01, 1'b0);
    check("sub_shl_c", datapath_out, 16'h7FFD);
    check("sub_shl_z", Z_out, 3'b000);
    alu_op(3'b000, 2'b00, 1'b0);
    check("add_ovf_c", datapath_out, 16'h8000);
    check("add_ovf_z", Z_out, 3'b110);

    // Shift modes with Ain forced to zero
    wr_imm(3'd4, 16'h8001);
    load_ab(3'd2, 3'd4);
    alu_op(3'b000, 2'b10, 1'b1);
    check("lsr_c", datapath_out, 16'h4000);
    alu_op(3'b000, 2'b11, 1'b1);
    check("asr_c", datapath_out, 16'hC000);
    check("asr_z", Z_out, 3'b010);
    alu_op(3'b000, 2'b01, 1'b1);
    check("lsl_c", datapath_out, 16'h0002);

    // Remaining ALU ops, A=7FFF B=8001
    for (int i = 0; i < 6; i++) begin
      alu_op(op_tab[i], 2'b00, 1'b0);
      check($sformatf("op%0d_c", i), datapath_out, c_tab[i]);
      check($sformatf("op%0d_z", i), Z_out, z_tab[i]);
    end

    // Write-back sources; C is FFFE here
    PC = 8'hAB; vsel = 4'b0100; writenum = 3'd5; write = 1; tick(); clr();
    mdata = 16'h1234; vsel = 4'b0001; writenum = 3'd6; write = 1; tick(); clr();
    vsel = 4'b1000; writenum = 3'd7; write = 1; tick(); clr();
    read_reg(3'd5, rv); check("wb_pc", rv, 16'h00AB);
    read_reg(3'd6, rv); check("wb_mdata", rv, 16'h1234);
    read_reg(3'd7, rv); check("wb_c", rv, 16'hFFFE);

    // Illegal vsel suppresses the write
    mdata = 16'hDEAD; sximm8 = 16'hBEEF; vsel = 4'b0011; writenum = 3'd5; write = 1;
    tick(); clr();
    read_reg(3'd5, rv); check("vsel_bad", rv, 16'h00AB);

    // MUL opcode without loadc: flags of the add, nothing starts
    load_ab(3'd2, 3'd3);
    ALUop = 3'b110; loads = 1; tick(); clr();
    check("mul_nolc_busy", busy, 1'b0);
    check("mul_nolc_z", Z_out, 3'b110);
    check("mul_nolc_c", datapath_out, 16'h00AB);

    // 300*300 with A/B reloads, ignored loadc and a register write mid-run
    wr_imm(3'd0, 16'd300);
    wr_imm(3'd1, 16'd300);
    wr_imm(3'd2, 16'd3);
    wr_imm(3'd3, 16'd5);
    load_ab(3'd0, 3'd1);
    ALUop = 3'b110; loadc = 1; loads = 1; tick(); clr();
    check("mul1_start_busy", busy, 1'b1);
    check("mul1_start_c", datapath_out, 16'h00AB);
    check("mul1_start_z", Z_out, 3'b110);
    mul_wait(1, cyc, dn);
    check("mul1_cycles", cyc, 16);
    check("mul1_done", dn, 1);
    check("mul1_c", datapath_out, 16'h5F90);
    check("mul1_z", Z_out, 3'b100);

    // Back-to-back 3*5 started on the done cycle, loads=0
    ALUop = 3'b110; loadc = 1; loads = 0; tick(); clr();
    check("mul2_start_busy", busy, 1'b1);
    mul_wait(2, cyc, dn);
    check("mul2_cycles", cyc, 16);
    check("mul2_done", dn, 1);
    check("mul2_c", datapath_out, 16'd15);
    check("mul2_z", Z_out, 3'b100);
    tick();
    check("mul2_done_drop", done, 1'b0);
    read_reg(3'd0, rv); check("mul_midrun_wr", rv, 16'h0042);

    // Reset five cycles into a multiply, with a write and loadc in the reset cycle
    ALUop = 3'b110; loadc = 1; loads = 1; tick(); clr();
    for (int i = 0; i < 4; i++) tick();
    check("abort_pre_busy", busy, 1'b1);
    reset = 1; loadc = 1; loads = 1; write = 1; vsel = 4'b0010; sximm8 = 16'h0099;
    writenum = 3'd1;
    tick();
    reset = 0; clr();
    check("abort_busy", busy, 1'b0);
    check("abort_c", datapath_out, 16'h0);
    check("abort_z", Z_out, 3'b000);
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dn++;
      tick();
    end
    check("abort_no_done", dn, 0);
    check("abort_c_hold", datapath_out, 16'h0);
    for (int r = 0; r < 8; r++) begin
      read_reg(3'(r), rv);
      check($sformatf("abort_r%0d", r), rv, 16'h0);
    end

    // Wide instance
    tick();
    w_reset = 0;
    check("w_rst_c", w_datapath_out, 32'h0);
    w_wr(4'd0, 32'd7);
    w_wr(4'd9, 32'd2);
    w_load(4'd0, 4'd9);
    w_ALUop = 3'b000; w_loadc = 1; w_loads = 1; tick(); w_clr();
    check("w_add_c", w_datapath_out, 32'd9);
    check("w_add_z", w_Z_out, 3'b000);
    w_wr(4'd2, 32'd300);
    w_wr(4'd3, 32'd300);
    w_load(4'd2, 4'd3);
    w_ALUop = 3'b110; w_loadc = 1; w_loads = 1; tick(); w_clr();
    cyc = 0; dn = 0;
    while (w_busy && cyc < 200) begin
      cyc++;
      if (w_done) dn++;
      tick();
    end
    if (w_done) dn++;
    check("w_mul_cycles", cyc, 32);
    check("w_mul_done", dn, 1);
    check("w_mul_c", w_datapath_out, 32'd90000);
    check("w_mul_z", w_Z_out, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/datapath_gen.md
DATAPATH_GEN -- requirements
Module: datapath_gen

Interface
REQ-001 Parameters SHALL be: W, 16, data width; NREG, 8, register count (power of 2, >=2); RW, log2(NREG), register index width; PCW, 8, PC width (PCW<=W).
REQ-002 Clock and reset SHALL be synchronous, active-high; ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-003 Ports: readnum  in  RW  register read index; writenum  in  RW  register write index; write  in  1  register write enable.
REQ-004 Ports: loada, loadb, loadc, loads  in  1 each  enables for A, B, C, status; asel, bsel  in  1 each  A-zero select, B-immediate select.
REQ-005 Ports: vsel  in  4  one-hot write-back select; ALUop  in  3  operation; shift  in  2  B shift mode.
REQ-006 Ports: sximm5, sximm8, mdata  in  W each  immediates and memory data; PC  in  PCW  program counter.
REQ-007 Ports: datapath_out  out  W  C register; Z_out  out  3  {V,N,Z} status register; busy  out  1  multiply in progress; done  out  1  multiply-complete pulse.

Function
REQ-008 Register file: NREG x W; combinational read of readnum; write on rising clk when write=1 and vsel legal; read-during-write returns old value.
REQ-009 Write-back: vsel 0001 mdata; 0010 sximm8; 0100 {zeros,PC}; 1000 datapath_out; any other vsel SHALL suppress the write (no register changes).
REQ-010 A and B SHALL load the register-file read value on clk when loada/loadb=1, independent of busy.
REQ-011 Ain = asel ? 0 : A; Bin = bsel ? sximm5 : shift(B).
REQ-012 Shift: 00 pass; 01 left 1, zero fill; 10 logical right 1; 11 arithmetic right 1 (MSB replicated).
REQ-013 ALUop: 000 Ain+Bin; 001 Ain-Bin; 010 Ain&Bin; 011 ~Bin; 100 Ain|Bin; 101 Ain^Bin; 110 MUL; 111 SHALL behave as 000. All results mod 2^W.
REQ-014 Single-cycle ops: C <= result when loadc=1; status <= flags when loads=1; latency 1 clk.
REQ-015 Flags: Z = (result==0); N = result[W-1]; V = signed overflow for ADD/SUB/111, else 0.
REQ-016 MUL state machine, states IDLE, RUN: IDLE with ALUop=110 and loadc=1 SHALL capture Ain, Bin, loads; go to RUN; busy=1 next cycle; C and status unchanged at that edge.
REQ-017 RUN: unsigned shift-add, one multiplier bit per cycle, exactly W cycles; 2W-bit product.
REQ-018 Completion edge: C <= product[W-1:0]; if captured loads=1, status <= {V: product[2W-1:W]!=0, N: product[W-1], Z: product[W-1:0]==0}; busy->0; done=1 for exactly one cycle; return to IDLE.
REQ-019 Result visible on datapath_out W+1 cycles after start edge; back-to-back MUL SHALL start on the cycle done is high.
REQ-020 While busy: loadc, loads ignored; A/B loads and register writes permitted and SHALL NOT affect the running product.
REQ-021 ALUop=110 with loadc=0 SHALL start nothing; loads=1 in that case SHALL load flags of Ain+Bin.

Reset
REQ-022 reset=1 at a rising edge SHALL clear all registers, A, B, C, status, busy, done to 0 and force IDLE, overriding every other input.
REQ-023 Reset during RUN SHALL abort the multiply; no done pulse, C stays 0.
REQ-024 Register writes requested in a reset cycle SHALL be discarded.

Verification
REQ-025 Reset, vsel=0010 sximm8=7 write R0; vsel=0010 sximm8=2 write R1; A<=R0, B<=R1; ALUop=000 loadc loads -> datapath_out=9, Z_out=000.
REQ-026 A=0x7FFF, B=1, ALUop=001 with shift=01 (Bin=2) -> C=0x7FFD, Z_out=000; A=0x7FFF, B=1, ALUop=000 -> C=0x8000, Z_out=110.
REQ-027 A=300, B=300, ALUop=110 loadc loads -> busy high 16 cycles; done one cycle; C=0x5F90, Z_out=100 (product 90000 > 0xFFFF).
REQ-028 Start MUL A=3, B=5, change A and write R0 mid-run -> C=15, R0 updated, loadc mid-run ignored.
REQ-029 Reset asserted 5 cycles into MUL -> busy=0, done never pulses, C=0, all registers read 0.
REQ-030 vsel=0011 with write=1 -> target register unchanged; W=32, NREG=16 instance repeats REQ-025 and REQ-027 (32-cycle busy).
